// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the fifo_wr_arb burst write arbiter.
// Requester indices select bits of the one-hot grant and pick vectors.
package fifo_wr_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 3;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_wr_arb_rr_pick2.sv
// Combinational two-way picker. Define FIFO_WR_ARB_PRIO_EN for fixed priority
// (req[0] wins ties); otherwise ties go to the requester not recorded in last.
module rr_pick2
  import fifo_wr_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

`ifdef FIFO_WR_ARB_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = '0;
`ifdef FIFO_WR_ARB_PRIO_EN
      pick[REQ0] = 1'b1;
`else
      // last == 1 means requester 1 owned the previous grant
      if (last) pick[REQ0] = 1'b1;
      else      pick[REQ1] = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst write arbiter sharing one fifo write port between two producers.
// Define FIFO_WR_ARB_PRIO_EN for fixed priority instead of round-robin.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              ready0,
  output logic              ready1,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_din,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  state_t           state;
  logic [LEN_W-1:0] remain;
  logic             last;
  logic [1:0]       req;
  logic [1:0]       pick;
  logic [1:0]       rdy;
  logic             own_req;

  assign req     = {req1, req0};
  assign rdy     = gnt & req & {2{~fifo_full}};
  assign ready0  = rdy[REQ0];
  assign ready1  = rdy[REQ1];
  assign fifo_wr = |rdy;
  assign own_req = |(gnt & req);

  always_comb begin
    fifo_din = '0;
    if (gnt[REQ0])      fifo_din = din0;
    else if (gnt[REQ1]) fifo_din = din1;
  end

  rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .pick (pick)
  );

`ifdef FIFO_WR_ARB_PRIO_EN
  assign last = 1'b0;
`else
  always_ff @(posedge clk) begin
    if (rst)                         last <= 1'b1;
    else if (state == IDLE && |req)  last <= pick[REQ1];
  end
`endif

  // Grant/transfer control: one whole burst per grant, IDLE gap between bursts
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      abort  <= 1'b0;
      remain <= '0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= XFER;
            gnt    <= pick;
            busy   <= 1'b1;
            remain <= pick[REQ1] ? len1 : len0;
          end
        end
        XFER: begin
          // Dropped request wins over a full stall
          if (!own_req) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            abort <= 1'b1;
          end else if (fifo_wr) begin
            if (remain == '0) begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              remain <= remain - 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Burst-oriented write arbiter that shares the single write port of the 8-deep × 16-bit `fifo` between two producers. Each producer requests a burst of 1–8 words. The arbiter grants one whole burst at a time, using round-robin selection, or fixed priority when configured. It forwards data to `fifo` only while `full` is low, so the FIFO's `over` flag is never raised by this path. It sits directly in front of `fifo` and drives its `wr`/`din`.

## Interface
- `DATA_W`, 16, word width; matches `fifo` `din`.
- `LEN_W`, 3, burst-length field width; burst length = `lenN` + 1, so 1..8 words.
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `req0` / `req1`  input  1  burst request; also acts as the per-word valid for the whole burst.
- `len0` / `len1`  input  LEN_W  burst length minus 1; sampled only at grant.
- `din0` / `din1`  input  DATA_W  write data from each requester.
- `ready0` / `ready1`  output  1  word accepted this cycle.
- `fifo_full`  input  1  from `fifo` `full`.
- `fifo_wr`  output  1  to `fifo` `wr`.
- `fifo_din`  output  DATA_W  to `fifo` `din`.
- `gnt`  output  2  one-hot current owner; 0 when idle.
- `busy`  output  1  burst in progress.
- `done`  output  1  one-cycle pulse after the last word of a burst.
- `abort`  output  1  one-cycle pulse when a burst is cut short.

## Operation
- **States:** IDLE and XFER.
- **IDLE:**
  - If any `req` is high, pick a winner, latch its `len` into `remain`, set `gnt`, go to XFER.
  - With no request, stay in IDLE.
- **Round-robin selection:**
  - If only one requester is asserting, it wins.
  - If both assert, the winner is the one not recorded in `last`.
  - `last` is updated at each grant.
- **XFER, per-word handshake:**
  - `readyN = gnt[N] & reqN & !fifo_full` (combinational).
  - `fifo_wr` = ready of the owner.
  - `fifo_din` = owner's `din` when granted, else 0.
- **XFER, progress:**
  - Each accepted word decrements `remain`.
  - The word accepted with `remain == 0` is the last word. The next state is IDLE, `gnt` clears, and `done` pulses in the following cycle.
- **Stall on full:** with `fifo_full` high, no word is accepted, `remain` and the state hold, and there is no timeout.
- **Abort:**
  - If the owner drops `req` during XFER, no word is written that cycle.
  - The next state is IDLE and `abort` pulses in the following cycle.
  - Words already written stay in `fifo`.
- **Non-owner:** its `ready` stays 0 regardless of its `req`; its request is held off until the next IDLE.
- **Width rules:**
  - `remain` is LEN_W bits and never wraps: it is compared to 0 before the decrement.
  - A burst of `len = 7` writes exactly 8 words.

## Timing
- **Reset values:**
  - State IDLE, `gnt` = 0, `last` = 1 (so `req0` wins the first tie), `remain` = 0.
  - `busy` = 0, `done` = 0, `abort` = 0.
  - `fifo_wr` = 0, `ready*` = 0, `fifo_din` = 0.
- **Grant latency:** `req` sampled high at edge t → `gnt`/`busy` high after edge t; the first word can be accepted in the cycle between edges t and t+1.
- **Gap between bursts:** there is a mandatory one-cycle IDLE gap, so the sustained rate for B-word bursts is B/(B+1).
- **`done` / `abort`:** registered, high for exactly one cycle, and coincident with the IDLE gap cycle.
- **Full drop-through:** `fifo_full` feeds `fifo_wr` combinationally, so a word is written in the same cycle that `full` drops.
- **Reset mid-burst:** next cycle is IDLE with all outputs at reset values; `done`/`abort` are not pulsed. The partial burst remains in `fifo` (no flush).
- **Full + req drop:** `fifo_full` high and owner `req` low in the same cycle is an abort, not a stall.

## Configuration
- **`FIFO_WR_ARB_PRIO_EN` defined:**
  - Fixed priority: `req0` always wins when both requesters are asserting.
  - `last` is not implemented.
- **Undefined (default):** round-robin as described in Operation.
- In both modes a granted burst is never preempted.

## Structure
- **Package `fifo_wr_arb_pkg`:**
  - State encoding: IDLE = 0, XFER = 1.
  - `DATA_W` / `LEN_W` defaults.
  - Requester index constants `REQ0` = 0, `REQ1` = 1.
- **Sub-module `rr_pick2`:**
  - Purely combinational two-way picker.
  - Inputs: `req[1:0]`, `last`. Output: one-hot `pick[1:0]`.
  - The `FIFO_WR_ARB_PRIO_EN` switch lives inside it.
- `fifo_wr_arb` holds the state register, `remain`, `last` and the output pulses.

## Test plan
- **Single burst:** `req0` high, `len0` = 3, `fifo` empty → `gnt` = 01 next cycle, 4 consecutive `fifo_wr` with data 0xA000..0xA003, `done` pulse, `fifo` count 4.
- **Tie round-robin:** `req0` and `req1` held high, `len` = 0 each → grant order 0,1,0,1; one idle cycle between grants; `fifo` receives alternating sources.
- **Stall on full:** preload 6 words, `req1` `len1` = 3 → 2 writes, `fifo_full` high, `ready1` = 0 while full; pop 1 → third word written in the same cycle `full` drops; remaining word written after the next pop; `over` never asserts.
- **Abort:** `req0` `len0` = 7, drop `req0` after 3 words → `abort` pulse, no `done`, `fifo` holds 3 words, `req1` granted next.
- **Reset mid-burst:** `rst` pulse during word 2 of an 8-word burst → next cycle `gnt` = 0, `busy` = 0, no pulses; a fresh tie then grants `req0`.
- **Priority build:** with `FIFO_WR_ARB_PRIO_EN` defined, both requesters always asserting → `req0` granted every time, `req1` never granted.
